// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback; loads/stores use a word-aligned data port.
// Latency: non-memory 1 cycle, store 1 + cycles until request accept (min 2), load min 3 (response-bound).
// Backpressure: in_ready only in IDLE; request fields held until dreq_ready; unbounded wait for dresp_valid.
// Optional: define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned half/word accesses without a memory request.
module mem_stage #(
  parameter int XLEN      = 32,
  parameter int IID_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_inst,
  input  logic [IID_WIDTH-1:0] in_inst_id,
  input  logic                 in_rf_wen,
  input  logic [4:0]           in_reg_addr,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [XLEN-1:0]      in_store_data,
  input  logic [1:0]           in_mem_op,
  input  logic [1:0]           in_mem_size,
  input  logic                 in_mem_unsigned,
  output logic                 dreq_valid,
  input  logic                 dreq_ready,
  output logic                 dreq_wen,
  output logic [XLEN-1:0]      dreq_addr,
  output logic [XLEN-1:0]      dreq_wdata,
  output logic [3:0]           dreq_wmask,
  input  logic                 dresp_valid,
  input  logic [XLEN-1:0]      dresp_rdata,
  output logic                 wb_valid,
  output logic [XLEN-1:0]      wb_pc,
  output logic [31:0]          wb_inst,
  output logic [IID_WIDTH-1:0] wb_inst_id,
  output logic                 wb_rf_wen,
  output logic [4:0]           wb_reg_addr,
  output logic [XLEN-1:0]      wb_wdata,
  output logic                 wb_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Captured instruction fields
  logic [XLEN-1:0]      r_pc;
  logic [31:0]          r_inst;
  logic [IID_WIDTH-1:0] r_iid;
  logic                 r_rf_wen;
  logic [4:0]           r_rd;
  logic [XLEN-1:0]      r_alu;
  logic [XLEN-1:0]      r_sdata;
  logic                 r_is_store;
  logic [1:0]           r_size;
  logic                 r_uns;

  // Writeback output registers
  logic                 r_wb_valid;
  logic [XLEN-1:0]      r_wb_pc;
  logic [31:0]          r_wb_inst;
  logic [IID_WIDTH-1:0] r_wb_iid;
  logic                 r_wb_rf_wen;
  logic [4:0]           r_wb_rd;
  logic [XLEN-1:0]      r_wb_wdata;
  logic                 r_wb_misalign;

  logic                 w_accept;
  logic                 w_in_is_mem;
  logic                 w_trap;
  logic                 w_req_fire;
  logic                 w_resp_fire;
  logic [1:0]           w_off;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [XLEN-1:0]      w_load_val;

  assign w_off       = r_alu[1:0];
  assign w_in_is_mem = (in_mem_op == 2'd1) || (in_mem_op == 2'd2);
  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_req_fire  = (r_state == S_REQ) && dreq_ready;
  assign w_resp_fire = (r_state == S_RESP) && dresp_valid;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  // Misaligned half (odd address) or word (any offset) completes as a fault with no request
  assign w_trap = w_in_is_mem &&
                  (((in_mem_size == 2'd1) && in_alu_result[0]) ||
                   ((in_mem_size[1]) && (in_alu_result[1:0] != 2'b00)));
`else
  assign w_trap = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    dreq_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_accept && w_in_is_mem && !w_trap) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        dreq_valid = 1'b1;
        if (dreq_ready) begin
          w_state_nxt = r_is_store ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        if (dresp_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request fields come straight from the captured instruction, so they stay stable while waiting
  always_comb begin
    dreq_wen   = 1'b0;
    dreq_addr  = '0;
    dreq_wdata = '0;
    dreq_wmask = 4'b0000;
    if (r_state == S_REQ) begin
      dreq_wen  = r_is_store;
      dreq_addr = {r_alu[XLEN-1:2], 2'b00};
      if (r_is_store) begin
        case (r_size)
          2'd0: begin
            dreq_wmask = 4'b0001 << w_off;
            dreq_wdata = {4{r_sdata[7:0]}};
          end
          2'd1: begin
            dreq_wmask = w_off[1] ? 4'b1100 : 4'b0011;
            dreq_wdata = {2{r_sdata[15:0]}};
          end
          default: begin
            dreq_wmask = 4'b1111;
            dreq_wdata = r_sdata;
          end
        endcase
      end
    end
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    w_byte     = dresp_rdata[8*w_off +: 8];
    w_half     = dresp_rdata[16*w_off[1] +: 16];
    w_load_val = dresp_rdata;
    case (r_size)
      2'd0:    w_load_val = r_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'd1:    w_load_val = r_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_val = dresp_rdata;
    endcase
  end

  // Capture the instruction on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_inst     <= '0;
      r_iid      <= '0;
      r_rf_wen   <= 1'b0;
      r_rd       <= '0;
      r_alu      <= '0;
      r_sdata    <= '0;
      r_is_store <= 1'b0;
      r_size     <= '0;
      r_uns      <= 1'b0;
    end else if (w_accept) begin
      r_pc       <= in_pc;
      r_inst     <= in_inst;
      r_iid      <= in_inst_id;
      r_rf_wen   <= in_rf_wen;
      r_rd       <= in_reg_addr;
      r_alu      <= in_alu_result;
      r_sdata    <= in_store_data;
      r_is_store <= (in_mem_op == 2'd2);
      r_size     <= in_mem_size;
      r_uns      <= in_mem_unsigned;
    end
  end

  // Writeback bundle: single-cycle valid pulse, fields hold their last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid    <= 1'b0;
      r_wb_pc       <= '0;
      r_wb_inst     <= '0;
      r_wb_iid      <= '0;
      r_wb_rf_wen   <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_wdata    <= '0;
      r_wb_misalign <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_accept && (!w_in_is_mem || w_trap)) begin
        r_wb_valid    <= 1'b1;
        r_wb_pc       <= in_pc;
        r_wb_inst     <= in_inst;
        r_wb_iid      <= in_inst_id;
        r_wb_rf_wen   <= !w_trap && in_rf_wen && (in_reg_addr != 5'd0);
        r_wb_rd       <= in_reg_addr;
        r_wb_wdata    <= w_trap ? '0 : in_alu_result;
        r_wb_misalign <= w_trap;
      end else if (w_req_fire && r_is_store) begin
        r_wb_valid    <= 1'b1;
        r_wb_pc       <= r_pc;
        r_wb_inst     <= r_inst;
        r_wb_iid      <= r_iid;
        r_wb_rf_wen   <= 1'b0;
        r_wb_rd       <= r_rd;
        r_wb_wdata    <= '0;
        r_wb_misalign <= 1'b0;
      end else if (w_resp_fire) begin
        r_wb_valid    <= 1'b1;
        r_wb_pc       <= r_pc;
        r_wb_inst     <= r_inst;
        r_wb_iid      <= r_iid;
        r_wb_rf_wen   <= r_rf_wen && (r_rd != 5'd0);
        r_wb_rd       <= r_rd;
        r_wb_wdata    <= w_load_val;
        r_wb_misalign <= 1'b0;
      end
    end
  end

  assign wb_valid    = r_wb_valid;
  assign wb_pc       = r_wb_pc;
  assign wb_inst     = r_wb_inst;
  assign wb_inst_id  = r_wb_iid;
  assign wb_rf_wen   = r_wb_rf_wen;
  assign wb_reg_addr = r_wb_rd;
  assign wb_wdata    = r_wb_wdata;
  assign wb_misalign = r_wb_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed stimulus for mem_stage against a queue-based reference model.
// A responder process plays the data memory with per-instruction ready/response delays.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [7:0]  in_inst_id;
  logic        in_rf_wen;
  logic [4:0]  in_reg_addr;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [1:0]  in_mem_op;
  logic [1:0]  in_mem_size;
  logic        in_mem_unsigned;
  logic        dreq_valid;
  logic        dreq_ready;
  logic        dreq_wen;
  logic [31:0] dreq_addr;
  logic [31:0] dreq_wdata;
  logic [3:0]  dreq_wmask;
  logic        dresp_valid;
  logic [31:0] dresp_rdata;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic [7:0]  wb_inst_id;
  logic        wb_rf_wen;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_wdata;
  logic        wb_misalign;

  mem_stage #(.XLEN(32), .IID_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_inst_id(in_inst_id), .in_rf_wen(in_rf_wen), .in_reg_addr(in_reg_addr),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data), .in_mem_op(in_mem_op),
    .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_wen(dreq_wen),
    .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata), .dreq_wmask(dreq_wmask),
    .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_inst_id(wb_inst_id),
    .wb_rf_wen(wb_rf_wen), .wb_reg_addr(wb_reg_addr), .wb_wdata(wb_wdata),
    .wb_misalign(wb_misalign)
  );

  typedef struct {
    logic [31:0] pc, inst, alu, sd;
    logic [7:0]  iid;
    logic        rf_wen, uns;
    logic [4:0]  rd;
    logic [1:0]  op, size;
  } ins_t;

  typedef struct {
    logic [31:0] pc, inst, wdata;
    logic [7:0]  iid;
    logic        rf_wen, mis;
    logic [4:0]  rd;
  } wb_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic        wen;
    logic [3:0]  wmask;
  } req_t;

  wb_t  exp_wb[$];
  req_t exp_req[$];
  logic [31:0] wb_hist[$];
  int          wb_cyc_hist[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wb_cnt = 0, hs_cnt = 0, hs_cyc = 0, wb_cyc = 0;
  int req_vcyc = 0, last_req_vcyc = 0;
  logic [31:0] last_req_addr, last_req_wdata, last_wb_wdata;
  logic [3:0]  last_req_wmask;
  logic        last_wb_rfwen, last_wb_mis;

  int          mem_rdy_dly = 0, mem_resp_dly = 0;
  logic [31:0] mem_rdata = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what the stage must produce for one instruction and a given memory word
  function automatic void model(input ins_t i, input logic [31:0] rdata,
                                output wb_t w, output logic has_req, output req_t r);
    logic [1:0]  off;
    logic [1:0]  sz;
    logic        mis;
    logic [31:0] v;
    off = i.alu[1:0];
    sz  = (i.size == 2'd3) ? 2'd2 : i.size;
    mis = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    mis = ((sz == 2'd1) && (off % 2 == 1)) || ((sz == 2'd2) && (off != 0));
`endif
    w.pc = i.pc; w.inst = i.inst; w.iid = i.iid; w.rd = i.rd; w.mis = 1'b0;
    r.addr = 32'h0; r.wdata = 32'h0; r.wen = 1'b0; r.wmask = 4'h0;
    has_req = 1'b0;
    if (i.op != 2'd1 && i.op != 2'd2) begin
      w.rf_wen = i.rf_wen && (i.rd != 0);
      w.wdata  = i.alu;
    end else if (mis) begin
      w.rf_wen = 1'b0; w.wdata = 32'h0; w.mis = 1'b1;
    end else begin
      has_req = 1'b1;
      r.addr  = i.alu & 32'hFFFF_FFFC;
      r.wen   = (i.op == 2'd2);
      if (r.wen) begin
        if (sz == 0) begin
          r.wmask = 4'(1 << off);
          r.wdata = (i.sd & 32'hFF) * 32'h0101_0101;
        end else if (sz == 1) begin
          r.wmask = (off >= 2) ? 4'd12 : 4'd3;
          r.wdata = (i.sd & 32'hFFFF) * 32'h0001_0001;
        end else begin
          r.wmask = 4'd15;
          r.wdata = i.sd;
        end
        w.rf_wen = 1'b0; w.wdata = 32'h0;
      end else begin
        if (sz == 0) begin
          v = (rdata >> (8 * off)) & 32'hFF;
          if (!i.uns && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 1) begin
          v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
          if (!i.uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
          v = rdata;
        end
        w.rf_wen = i.rf_wen && (i.rd != 0);
        w.wdata  = v;
      end
    end
  endfunction

  // Data memory responder
  initial begin
    logic is_load;
    dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (dreq_valid && rst_n) begin
        repeat (mem_rdy_dly) begin @(posedge clk); #1; end
        dreq_ready = 1'b1;
        is_load = !dreq_wen;
        @(posedge clk); #1;
        dreq_ready = 1'b0;
        if (is_load) begin
          repeat (mem_resp_dly) begin @(posedge clk); #1; end
          dresp_valid = 1'b1; dresp_rdata = mem_rdata;
          @(posedge clk); #1;
          dresp_valid = 1'b0; dresp_rdata = $urandom;
        end
      end
    end
  end

  // Compare process: every wb pulse and every request cycle is checked against the model queues
  initial forever begin
    wb_t  e;
    req_t q;
    @(negedge clk);
    if (rst_n) begin
      if (wb_valid) begin
        wb_cnt++; wb_cyc = cyc;
        wb_hist.push_back(wb_wdata); wb_cyc_hist.push_back(cyc);
        last_wb_wdata = wb_wdata; last_wb_rfwen = wb_rf_wen; last_wb_mis = wb_misalign;
        if (exp_wb.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: got wb_valid 1 expected 0");
        end else begin
          e = exp_wb.pop_front();
          chk("wb_pc", wb_pc, e.pc);
          chk("wb_inst", wb_inst, e.inst);
          chk("wb_inst_id", {24'h0, wb_inst_id}, {24'h0, e.iid});
          chk("wb_rf_wen", {31'h0, wb_rf_wen}, {31'h0, e.rf_wen});
          chk("wb_reg_addr", {27'h0, wb_reg_addr}, {27'h0, e.rd});
          chk("wb_wdata", wb_wdata, e.wdata);
          chk("wb_misalign", {31'h0, wb_misalign}, {31'h0, e.mis});
        end
      end
      if (dreq_valid) begin
        req_vcyc++;
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL dreq_unexpected: got dreq_valid 1 expected 0");
        end else begin
          q = exp_req[0];
          chk("dreq_addr", dreq_addr, q.addr);
          chk("dreq_wen", {31'h0, dreq_wen}, {31'h0, q.wen});
          chk("dreq_wdata", dreq_wdata, q.wdata);
          chk("dreq_wmask", {28'h0, dreq_wmask}, {28'h0, q.wmask});
          if (dreq_ready) begin
            void'(exp_req.pop_front());
            hs_cnt++; hs_cyc = cyc;
            last_req_addr = dreq_addr; last_req_wdata = dreq_wdata; last_req_wmask = dreq_wmask;
            last_req_vcyc = req_vcyc; req_vcyc = 0;
          end
        end
      end
    end
  end

  // Drive one instruction for one accepted cycle; called 1 unit after a rising edge
  task automatic send(input ins_t i, input int rdly, input int rsdly,
                      input logic [31:0] rdata, output int waited);
    wb_t  w;
    req_t r;
    logic hr;
    waited = 0;
    while (!in_ready && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got in_ready 0 expected 1");
      return;
    end
    in_pc = i.pc; in_inst = i.inst; in_inst_id = i.iid; in_rf_wen = i.rf_wen;
    in_reg_addr = i.rd; in_alu_result = i.alu; in_store_data = i.sd;
    in_mem_op = i.op; in_mem_size = i.size; in_mem_unsigned = i.uns;
    mem_rdy_dly = rdly; mem_resp_dly = rsdly; mem_rdata = rdata;
    model(i, rdata, w, hr, r);
    exp_wb.push_back(w);
    if (hr) exp_req.push_back(r);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_alu_result = $urandom; in_store_data = $urandom;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_wb.size() != 0 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_pending_wb", exp_wb.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  function automatic ins_t mk(input logic [1:0] op, input logic [1:0] size, input logic uns,
                              input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd);
    ins_t i;
    i.pc = 32'h8000_0000 + alu; i.inst = 32'h0000_0013 ^ sd; i.iid = alu[7:0] ^ 8'h5A;
    i.rf_wen = 1'b1; i.rd = rd; i.alu = alu; i.sd = sd;
    i.op = op; i.size = size; i.uns = uns;
    return i;
  endfunction

  initial begin
    ins_t i;
    int   w, n, hs0, wb0, bad, got;
    logic [31:0] rv;

    rst_n = 1'b0; in_valid = 1'b0; in_pc = 0; in_inst = 0; in_inst_id = 0; in_rf_wen = 0;
    in_reg_addr = 0; in_alu_result = 0; in_store_data = 0; in_mem_op = 0; in_mem_size = 0;
    in_mem_unsigned = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_dreq_valid", {31'h0, dreq_valid}, 32'h0);
    chk("rst_wb_wdata", wb_wdata, 32'h0);
    chk("rst_dreq_addr", dreq_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Non-memory back-to-back
    send(mk(2'd0, 2'd2, 1'b0, 32'd1, 32'h0, 5'd5), 0, 0, 32'h0, w);
    send(mk(2'd0, 2'd2, 1'b0, 32'd2, 32'h0, 5'd5), 0, 0, 32'h0, w);
    chk("b2b_wait2", w, 0);
    send(mk(2'd0, 2'd2, 1'b0, 32'd3, 32'h0, 5'd5), 0, 0, 32'h0, w);
    chk("b2b_wait3", w, 0);
    drain();
    n = wb_hist.size();
    if (n >= 3) begin
      chk("b2b_wdata0", wb_hist[n-3], 32'd1);
      chk("b2b_wdata1", wb_hist[n-2], 32'd2);
      chk("b2b_wdata2", wb_hist[n-1], 32'd3);
      chk("b2b_consecutive", wb_cyc_hist[n-1] - wb_cyc_hist[n-3], 2);
    end else chk("b2b_count", n, 3);

    // Signed and unsigned byte loads
    send(mk(2'd1, 2'd0, 1'b0, 32'h1003, 32'h0, 5'd6), 1, 2, 32'h80FF_FFFF, w);
    drain();
    chk("lb_addr", last_req_addr, 32'h1000);
    chk("lb_signed", last_wb_wdata, 32'hFFFF_FF80);
    send(mk(2'd1, 2'd0, 1'b1, 32'h1003, 32'h0, 5'd6), 0, 0, 32'h80FF_FFFF, w);
    drain();
    chk("lbu_unsigned", last_wb_wdata, 32'h0000_0080);

    // Store halfword with ready held low 4 cycles
    hs0 = hs_cnt; wb0 = wb_cnt;
    send(mk(2'd2, 2'd1, 1'b0, 32'h2002, 32'h1234_ABCD, 5'd9), 4, 0, 32'h0, w);
    drain();
    chk("sh_handshakes", hs_cnt - hs0, 1);
    chk("sh_wb_pulses", wb_cnt - wb0, 1);
    chk("sh_addr", last_req_addr, 32'h2000);
    chk("sh_wmask", {28'h0, last_req_wmask}, 32'hC);
    chk("sh_wdata", last_req_wdata, 32'hABCD_ABCD);
    chk("sh_req_cycles", last_req_vcyc, 5);
    chk("sh_rf_wen", {31'h0, last_wb_rfwen}, 32'h0);
    chk("sh_wb_after_accept", wb_cyc - hs_cyc, 1);

    // Load with 5-cycle response delay
    hs0 = hs_cnt; wb0 = wb_cnt; bad = 0; got = 0;
    send(mk(2'd1, 2'd2, 1'b0, 32'h4000, 32'h0, 5'd11), 0, 5, 32'h1122_3344, w);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wb_valid) begin
        got = 1;
        chk("lw_in_ready_at_wb", {31'h0, in_ready}, 32'h1);
        break;
      end else if (in_ready) bad++;
    end
    chk("lw_wb_seen", got, 1);
    chk("lw_busy_in_ready", bad, 0);
    repeat (4) @(negedge clk);
    chk("lw_wb_pulses", wb_cnt - wb0, 1);
    chk("lw_handshakes", hs_cnt - hs0, 1);
    @(posedge clk); #1;

    // Reset while waiting for the response, then a stale response
    wb0 = wb_cnt;
    send(mk(2'd1, 2'd2, 1'b0, 32'h5000, 32'h0, 5'd12), 0, 8, 32'hCAFE_F00D, w);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_wb.delete();
    exp_req.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("mid_rst_dreq_valid", {31'h0, dreq_valid}, 32'h0);
    chk("mid_rst_wb_pc", wb_pc, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (wb_valid || dreq_valid) bad++;
    end
    chk("stale_resp_ignored", bad, 0);
    chk("stale_wb_pulses", wb_cnt - wb0, 0);
    chk("stale_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;

    // Misaligned word load
    hs0 = hs_cnt;
    send(mk(2'd1, 2'd2, 1'b0, 32'h3002, 32'h0, 5'd7), 0, 1, 32'hDEAD_BEEF, w);
    drain();
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    chk("mis_no_request", hs_cnt - hs0, 0);
    chk("mis_flag", {31'h0, last_wb_mis}, 32'h1);
    chk("mis_rf_wen", {31'h0, last_wb_rfwen}, 32'h0);
`else
    chk("mis_request", hs_cnt - hs0, 1);
    chk("mis_addr", last_req_addr, 32'h3000);
    chk("mis_word", last_wb_wdata, 32'hDEAD_BEEF);
`endif

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      rv = $urandom;
      i.op = rv[1:0]; i.size = rv[3:2]; i.uns = rv[4]; i.rf_wen = rv[5];
      i.rd = (rv[8:6] == 3'd0) ? 5'd0 : rv[13:9];
      i.iid = rv[21:14];
      i.pc = $urandom; i.inst = $urandom; i.alu = $urandom; i.sd = $urandom;
      send(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, w);
    end
    drain();
    chk("end_req_queue", exp_req.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
